// File: rtl/instr_fetch_unit_if.sv
// instr_fetch_unit_if
//   Bundles the fetch unit's PC, instruction-memory and decode-side signals.
//   master : the fetch unit (drives pc_next, imem_req/addr, instr_valid/instr/instr_pc)
//   slave  : the surrounding PC register, instruction memory and decode stage
interface instr_fetch_unit_if #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32
);
    logic [ADDR_W-1:0]  fetch_pc;
    logic [ADDR_W-1:0]  pc_next;
    logic               redirect_valid;
    logic [ADDR_W-1:0]  redirect_pc;
    logic               imem_req;
    logic [ADDR_W-1:0]  imem_addr;
    logic               imem_gnt;
    logic               imem_rvalid;
    logic [INSTR_W-1:0] imem_rdata;
    logic               instr_valid;
    logic               instr_ready;
    logic [INSTR_W-1:0] instr;
    logic [ADDR_W-1:0]  instr_pc;

    modport master (
        input  fetch_pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
               imem_rdata, instr_ready,
        output pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
    );

    modport slave (
        output fetch_pc, redirect_valid, redirect_pc, imem_gnt, imem_rvalid,
               imem_rdata, instr_ready,
        input  pc_next, imem_req, imem_addr, instr_valid, instr, instr_pc
    );
endinterface

// File: rtl/instr_fetch_unit.sv
// instr_fetch_unit
//   Reads the current fetch PC, requests instructions from instruction memory,
//   tags each grant with its PC, buffers returned instructions with their PCs and
//   hands them to decode over valid/ready. Computes the PC's next value every
//   cycle (hold, +4 on grant, or aligned redirect target).
// Ports
//   clk, reset : clock, asynchronous active-high reset
//   bus        : instr_fetch_unit_if.master (fetch_pc/pc_next, redirect,
//                imem req/addr/gnt/rvalid/rdata, instr valid/ready/instr/instr_pc)
module instr_fetch_unit #(
    parameter int ADDR_W  = 64,
    parameter int INSTR_W = 32,
    parameter int DEPTH   = 2
) (
    input logic                clk,
    input logic                reset,
    instr_fetch_unit_if.master bus
);
    localparam int PW = $clog2(DEPTH);
    localparam int CW = PW + 1;

    logic [CW-1:0]      outstanding, count, drop;
    logic [CW:0]        inflight;
    logic [PW-1:0]      tag_wp, tag_rp, buf_wp, buf_rp;
    logic [ADDR_W-1:0]  tag_q    [DEPTH];
    logic [INSTR_W-1:0] buf_data [DEPTH];
    logic [ADDR_W-1:0]  buf_pc   [DEPTH];
    logic               redir, gnt_fire, rv_fire, push, pop, armed;
    logic [1:0]         unused_rpc_lsb;

    assign unused_rpc_lsb = bus.redirect_pc[1:0];

    assign redir    = !reset && bus.redirect_valid;
    // Outstanding requests plus buffered instructions bound the issue window,
    // so every response always has a buffer slot waiting for it.
    assign inflight = {1'b0, outstanding} + {1'b0, count};
    assign bus.imem_req  = !reset && !bus.redirect_valid && (inflight < (CW+1)'(DEPTH));
    assign bus.imem_addr = bus.fetch_pc;

    assign gnt_fire = bus.imem_req && bus.imem_gnt;
    // A response with nothing outstanding (e.g. one left over from before reset)
    // is ignored.
    assign rv_fire  = bus.imem_rvalid && (outstanding != '0);
    // Responses to requests issued before a redirect are discarded; so is one
    // arriving in the redirect cycle itself.
    assign push     = rv_fire && (drop == '0) && !redir;
    assign pop      = bus.instr_valid && bus.instr_ready;

    // Holding pc_next at fetch_pc keeps an ungranted request's address stable.
    assign bus.pc_next = redir    ? {bus.redirect_pc[ADDR_W-1:2], 2'b00} :
                         gnt_fire ? bus.fetch_pc + ADDR_W'(4) :
                                    bus.fetch_pc;

    assign bus.instr_valid = (count != '0);
    assign bus.instr       = bus.instr_valid ? buf_data[buf_rp] : '0;
    assign bus.instr_pc    = bus.instr_valid ? buf_pc[buf_rp]   : '0;

    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            outstanding <= '0;
            count       <= '0;
            drop        <= '0;
            tag_wp      <= '0;
            tag_rp      <= '0;
            buf_wp      <= '0;
            buf_rp      <= '0;
        end else begin
            outstanding <= outstanding + CW'(gnt_fire) - CW'(rv_fire);
            if (gnt_fire) tag_wp <= tag_wp + PW'(1);
            if (rv_fire)  tag_rp <= tag_rp + PW'(1);
            if (redir) begin
                // Everything still in flight belongs to the old path.
                count  <= '0;
                buf_wp <= '0;
                buf_rp <= '0;
                drop   <= outstanding - CW'(rv_fire);
            end else begin
                if (rv_fire && drop != '0) drop <= drop - CW'(1);
                if (push) buf_wp <= buf_wp + PW'(1);
                if (pop)  buf_rp <= buf_rp + PW'(1);
                count <= count + CW'(push) - CW'(pop);
            end
        end
    end

    // Storage needs no reset: occupancy is tracked by the pointers and counts.
    always_ff @(posedge clk) begin
        if (gnt_fire) tag_q[tag_wp] <= bus.fetch_pc;
        if (push) begin
            buf_data[buf_wp] <= bus.imem_rdata;
            buf_pc[buf_wp]   <= tag_q[tag_rp];
        end
    end

    // Responses still in flight across a reset are legal, so the protocol check
    // arms only once the new session has had a request granted.
    always_ff @(posedge clk or posedge reset) begin
        if (reset)         armed <= 1'b0;
        else if (gnt_fire) armed <= 1'b1;
    end

    always @(posedge clk) begin
        if (!reset && armed) assert (!(bus.imem_rvalid && outstanding == '0));
    end
endmodule
